// File: rtl/cpu_program_loader.sv
// Stream-driven program loader in front of the cpu external memory ports; writes header-described
// segments into imem/dmem, then enables the cpu. Define CPU_PROGRAM_LOADER_READBACK_EN for XOR readback verify.
module cpu_program_loader #(
    parameter int IMEM_AW   = 9,
    parameter int DMEM_AW   = 10,
    parameter int ADDR_STEP = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_s_valid,
    output logic        o_s_ready,
    input  logic [31:0] i_s_data,
    input  logic        i_halt,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_wen,
    output logic        o_imem_ren,
    output logic [31:0] o_imem_wdata,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_dmem_addr,
    output logic        o_dmem_wen,
    output logic        o_dmem_ren,
    output logic [31:0] o_dmem_wdata,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_cpu_enable,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);

`ifdef CPU_PROGRAM_LOADER_READBACK_EN
    typedef enum logic [1:0] {S_HDR = 2'd0, S_WRITE = 2'd1, S_VERIFY = 2'd2, S_RUN = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_HDR = 2'd0, S_WRITE = 2'd1, S_RUN = 2'd3} state_t;
`endif

    state_t               r_state, w_state_nx;
    logic                 r_region;
    logic [14:0]          r_base;
    logic [15:0]          r_count, r_idx;
    logic                 w_hs, w_last;
    logic [IMEM_AW-1:0]   w_iwrap;
    logic [DMEM_AW-1:0]   w_dwrap;
    logic [31:0]          w_iaddr, w_daddr;

    assign w_hs    = o_s_ready & i_s_valid;
    assign w_last  = (r_idx == r_count - 16'd1);
    // Word index wraps in the memory's own address width before scaling to bytes.
    assign w_iwrap = IMEM_AW'({1'b0, r_base} + r_idx);
    assign w_dwrap = DMEM_AW'({1'b0, r_base} + r_idx);
    assign w_iaddr = 32'(w_iwrap) * ADDR_STEP;
    assign w_daddr = 32'(w_dwrap) * ADDR_STEP;

`ifdef CPU_PROGRAM_LOADER_READBACK_EN
    logic        r_issue;
    logic [1:0]  r_vld_pipe, r_last_pipe;
    logic [31:0] r_wr_sum, r_rd_sum, w_rd_next;
    logic        r_error;

    assign w_rd_next = r_rd_sum ^ (r_region ? i_dmem_rdata : i_imem_rdata);
    assign o_error   = r_error;
`else
    logic w_unused_rdata;
    assign w_unused_rdata = ^{i_imem_rdata, i_dmem_rdata};
    assign o_error    = 1'b0;
    assign o_imem_ren = 1'b0;
    assign o_dmem_ren = 1'b0;
`endif

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_HDR:    if (w_hs) w_state_nx = (i_s_data[15:0] == 16'd0) ? S_RUN : S_WRITE;
`ifdef CPU_PROGRAM_LOADER_READBACK_EN
            S_WRITE:  if (w_hs && w_last) w_state_nx = S_VERIFY;
            S_VERIFY: if (r_vld_pipe[1] && r_last_pipe[1]) w_state_nx = S_HDR;
`else
            S_WRITE:  if (w_hs && w_last) w_state_nx = S_HDR;
`endif
            S_RUN:    if (i_halt) w_state_nx = S_HDR;
            default:  w_state_nx = S_HDR;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_HDR;
        else       r_state <= w_state_nx;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_s_ready    <= 1'b0;
            o_busy       <= 1'b0;
            o_cpu_enable <= 1'b0;
            o_done       <= 1'b0;
            o_imem_wen   <= 1'b0;
            o_imem_addr  <= '0;
            o_imem_wdata <= '0;
            o_dmem_wen   <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_wdata <= '0;
            r_region     <= 1'b0;
            r_base       <= '0;
            r_count      <= '0;
            r_idx        <= '0;
`ifdef CPU_PROGRAM_LOADER_READBACK_EN
            o_imem_ren   <= 1'b0;
            o_dmem_ren   <= 1'b0;
            r_issue      <= 1'b0;
            r_vld_pipe   <= '0;
            r_last_pipe  <= '0;
            r_wr_sum     <= '0;
            r_rd_sum     <= '0;
            r_error      <= 1'b0;
`endif
        end else begin
            // Status outputs are registered copies of the upcoming state.
            o_s_ready    <= (w_state_nx == S_HDR) || (w_state_nx == S_WRITE);
            o_busy       <= (w_state_nx != S_HDR) && (w_state_nx != S_RUN);
            o_cpu_enable <= (w_state_nx == S_RUN);
            o_done       <= 1'b0;
            o_imem_wen   <= 1'b0;
            o_dmem_wen   <= 1'b0;

            if (r_state == S_HDR && w_hs && i_s_data[15:0] != 16'd0) begin
                r_region <= i_s_data[31];
                r_base   <= i_s_data[30:16];
                r_count  <= i_s_data[15:0];
                r_idx    <= '0;
`ifdef CPU_PROGRAM_LOADER_READBACK_EN
                r_wr_sum <= '0;
`endif
            end

            if (r_state == S_WRITE && w_hs) begin
                if (r_region) begin
                    o_dmem_wen   <= 1'b1;
                    o_dmem_addr  <= w_daddr;
                    o_dmem_wdata <= i_s_data;
                end else begin
                    o_imem_wen   <= 1'b1;
                    o_imem_addr  <= w_iaddr;
                    o_imem_wdata <= i_s_data;
                end
                r_idx <= r_idx + 16'd1;
`ifdef CPU_PROGRAM_LOADER_READBACK_EN
                r_wr_sum <= r_wr_sum ^ i_s_data;
                if (w_last) begin
                    r_idx    <= '0;
                    r_issue  <= 1'b1;
                    r_rd_sum <= '0;
                end
`else
                if (w_last) o_done <= 1'b1;
`endif
            end

`ifdef CPU_PROGRAM_LOADER_READBACK_EN
            o_imem_ren  <= 1'b0;
            o_dmem_ren  <= 1'b0;
            // [0] marks a ren cycle, [1] the following cycle when rdata is valid.
            r_vld_pipe  <= {r_vld_pipe[0], r_issue};
            r_last_pipe <= {r_last_pipe[0], r_issue & w_last};
            if (r_issue) begin
                if (r_region) begin
                    o_dmem_ren  <= 1'b1;
                    o_dmem_addr <= w_daddr;
                end else begin
                    o_imem_ren  <= 1'b1;
                    o_imem_addr <= w_iaddr;
                end
                r_idx <= r_idx + 16'd1;
                if (w_last) r_issue <= 1'b0;
            end
            if (r_vld_pipe[1]) begin
                r_rd_sum <= w_rd_next;
                if (r_last_pipe[1]) begin
                    if (w_rd_next != r_wr_sum) r_error <= 1'b1;
                    o_done <= 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_cpu_program_loader.sv
// Directed bench for cpu_program_loader: segment writes, stalls, run/halt, wrap, mid-segment reset,
// and (with CPU_PROGRAM_LOADER_READBACK_EN) sticky readback error.
module tb_cpu_program_loader;
    logic        clk, rst, s_valid, s_ready, halt;
    logic [31:0] s_data;
    logic [31:0] imem_addr, imem_wdata, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic        imem_wen, imem_ren, dmem_wen, dmem_ren;
    logic        cpu_enable, busy, done, error;

    int          n_cmp = 0, n_bad = 0;
    int          done_cnt = 0, both_cnt = 0, ren_cnt = 0;
    logic [31:0] iq_a[$], iq_d[$], dq_a[$], dq_d[$];
    logic [31:0] imem_m[512];
    logic [31:0] dmem_m[1024];
    logic        corrupt = 1'b0;
    int          rd_n = 0;

    cpu_program_loader #(.IMEM_AW(9), .DMEM_AW(10), .ADDR_STEP(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_data(s_data),
        .i_halt(halt),
        .o_imem_addr(imem_addr), .o_imem_wen(imem_wen), .o_imem_ren(imem_ren),
        .o_imem_wdata(imem_wdata), .i_imem_rdata(imem_rdata),
        .o_dmem_addr(dmem_addr), .o_dmem_wen(dmem_wen), .o_dmem_ren(dmem_ren),
        .o_dmem_wdata(dmem_wdata), .i_dmem_rdata(dmem_rdata),
        .o_cpu_enable(cpu_enable), .o_busy(busy), .o_done(done), .o_error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model; second readback word is flipped while corrupt is set.
    always @(posedge clk) begin
        if (imem_wen) imem_m[imem_addr[10:2]] <= imem_wdata;
        if (dmem_wen) dmem_m[dmem_addr[11:2]] <= dmem_wdata;
        if (imem_ren) imem_rdata <= imem_m[imem_addr[10:2]] ^ ((corrupt && rd_n == 1) ? 32'h100 : 32'h0);
        if (dmem_ren) dmem_rdata <= dmem_m[dmem_addr[11:2]] ^ ((corrupt && rd_n == 1) ? 32'h100 : 32'h0);
        if (corrupt && (imem_ren || dmem_ren)) rd_n <= rd_n + 1;
    end

    always @(negedge clk) begin
        if (imem_wen) begin iq_a.push_back(imem_addr); iq_d.push_back(imem_wdata); end
        if (dmem_wen) begin dq_a.push_back(dmem_addr); dq_d.push_back(dmem_wdata); end
        if (imem_wen && dmem_wen) both_cnt++;
        if (done) done_cnt++;
        if (imem_ren || dmem_ren) ren_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clr();
        iq_a.delete(); iq_d.delete(); dq_a.delete(); dq_d.delete();
        done_cnt = 0;
    endtask

    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = w;
        while (!s_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("send_ready_timeout", 32'(s_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; halt = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready",  32'(s_ready), 32'd0);
        chk("rst_enable", 32'(cpu_enable), 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_done",   32'(done), 32'd0);
        chk("rst_error",  32'(error), 32'd0);
        chk("rst_wen",    32'({imem_wen, dmem_wen}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(s_ready), 32'd1);

        // imem segment, back-to-back payload
        clr();
        send(32'h0000_0003); send(32'h11); send(32'h22); send(32'h33);
        idle(10);
        chk("t1_icount", 32'(iq_a.size()), 32'd3);
        if (iq_a.size() == 3) begin
            chk("t1_a0", iq_a[0], 32'd0); chk("t1_a1", iq_a[1], 32'd4); chk("t1_a2", iq_a[2], 32'd8);
            chk("t1_d0", iq_d[0], 32'h11); chk("t1_d1", iq_d[1], 32'h22); chk("t1_d2", iq_d[2], 32'h33);
        end
        chk("t1_dcount", 32'(dq_a.size()), 32'd0);
        chk("t1_done",   32'(done_cnt), 32'd1);
        chk("t1_busy",   32'(busy), 32'd0);
        chk("t1_error",  32'(error), 32'd0);

        // dmem segment, base 5
        clr();
        send(32'h8005_0002); send(32'hAAAA_0000); send(32'h5555_FFFF);
        idle(10);
        chk("t2_dcount", 32'(dq_a.size()), 32'd2);
        if (dq_a.size() == 2) begin
            chk("t2_a0", dq_a[0], 32'd20); chk("t2_a1", dq_a[1], 32'd24);
            chk("t2_d0", dq_d[0], 32'hAAAA_0000); chk("t2_d1", dq_d[1], 32'h5555_FFFF);
        end
        chk("t2_icount",     32'(iq_a.size()), 32'd0);
        chk("t2_imem_hold",  imem_addr, 32'd8);
        chk("t2_done",       32'(done_cnt), 32'd1);

        // stalls between payload words
        clr();
        send(32'h0000_0003);
        for (int i = 0; i < 3; i++) begin
            send(32'h11 * (i + 1));
            @(negedge clk);
            s_valid = 1'b0;
            if (i < 2) chk("t3_busy_gap", 32'(busy), 32'd1);
            @(negedge clk);
        end
        idle(10);
        chk("t3_icount", 32'(iq_a.size()), 32'd3);
        if (iq_a.size() == 3) begin
            chk("t3_a0", iq_a[0], 32'd0); chk("t3_a1", iq_a[1], 32'd4); chk("t3_a2", iq_a[2], 32'd8);
            chk("t3_d2", iq_d[2], 32'h33);
        end
        chk("t3_done", 32'(done_cnt), 32'd1);

        // run / halt
        clr();
        send(32'h0000_0000);
        @(negedge clk);
        s_valid = 1'b0;
        chk("t4_enable", 32'(cpu_enable), 32'd1);
        chk("t4_ready",  32'(s_ready), 32'd0);
        chk("t4_busy",   32'(busy), 32'd0);
        s_valid = 1'b1; s_data = 32'h0000_0001;
        repeat (3) @(negedge clk);
        s_valid = 1'b0;
        chk("t4_enable_hold", 32'(cpu_enable), 32'd1);
        chk("t4_ignored",     32'(iq_a.size() + dq_a.size()), 32'd0);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk("t4_halt_enable", 32'(cpu_enable), 32'd0);
        chk("t4_halt_ready",  32'(s_ready), 32'd1);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk("t4_halt_hdr_ready", 32'(s_ready), 32'd1);

        // imem wrap at base 511
        clr();
        send(32'h01FF_0002); send(32'hA1); send(32'hB2);
        idle(10);
        chk("t5_icount", 32'(iq_a.size()), 32'd2);
        if (iq_a.size() == 2) begin
            chk("t5_a0", iq_a[0], 32'd2044); chk("t5_a1", iq_a[1], 32'd0);
            chk("t5_d1", iq_d[1], 32'hB2);
        end

        // reset in the middle of a segment
        clr();
        send(32'h0010_0003); send(32'hC1);
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b1; s_data = 32'hC2;
        @(negedge clk);
        chk("t6_rst_ready",  32'(s_ready), 32'd0);
        chk("t6_rst_busy",   32'(busy), 32'd0);
        chk("t6_rst_wen",    32'({imem_wen, dmem_wen, imem_ren, dmem_ren}), 32'd0);
        chk("t6_rst_addr",   imem_addr, 32'd0);
        chk("t6_rst_wdata",  imem_wdata, 32'd0);
        rst = 1'b0; s_valid = 1'b0;
        idle(3);
        chk("t6_icount", 32'(iq_a.size()), 32'd1);
        if (iq_a.size() == 1) chk("t6_a0", iq_a[0], 32'd64);
        chk("t6_ready", 32'(s_ready), 32'd1);
        clr();
        send(32'h0020_0001); send(32'h77);
        idle(10);
        chk("t6_next_count", 32'(iq_a.size()), 32'd1);
        if (iq_a.size() == 1) begin
            chk("t6_next_a", iq_a[0], 32'd128); chk("t6_next_d", iq_d[0], 32'h77);
        end
        chk("t6_next_done", 32'(done_cnt), 32'd1);

`ifdef CPU_PROGRAM_LOADER_READBACK_EN
        // corrupted readback -> sticky error
        clr();
        chk("t7_error_pre", 32'(error), 32'd0);
        corrupt = 1'b1;
        send(32'h8000_0003); send(32'h1); send(32'h2); send(32'h3);
        idle(12);
        corrupt = 1'b0;
        chk("t7_error", 32'(error), 32'd1);
        chk("t7_done",  32'(done_cnt), 32'd1);
        send(32'h0000_0001); send(32'h5);
        idle(10);
        chk("t7_error_sticky", 32'(error), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("t7_error_rst", 32'(error), 32'd0);
        rst = 1'b0;
        @(negedge clk);
`else
        chk("ren_never", 32'(ren_cnt), 32'd0);
        chk("error_never", 32'(error), 32'd0);
`endif
        chk("never_both_wen", 32'(both_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cpu_program_loader.md
Name: cpu_program_loader

Overview:
- Front-end loader that sits directly upstream of the cpu top's external memory ports.
- Accepts a valid/ready word stream of segment headers and payload words. Writes payload into instruction memory (addr_ext/wen_ext/wdata_ext) or data memory (addr_ext_2/wen_ext_2/wdata_ext_2).
- Drives the cpu enable input once loading is finished, and drops it again on a halt request so a new program can be loaded.

Parameters:
IMEM_AW, 9, instruction memory word-index width; indices wrap modulo 2^IMEM_AW
DMEM_AW, 10, data memory word-index width; indices wrap modulo 2^DMEM_AW
ADDR_STEP, 4, byte stride per word; address out = word index * ADDR_STEP

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
s_valid  in  1  stream word valid
s_ready  out  1  stream word accepted when s_valid&&s_ready
s_data  in  32  stream word (header or payload)
halt  in  1  single-cycle request to stop the cpu and return to loading
imem_addr  out  32  to cpu addr_ext
imem_wen  out  1  to cpu wen_ext
imem_ren  out  1  to cpu ren_ext
imem_wdata  out  32  to cpu wdata_ext
imem_rdata  in  32  from cpu rdata_ext
dmem_addr  out  32  to cpu addr_ext_2
dmem_wen  out  1  to cpu wen_ext_2
dmem_ren  out  1  to cpu ren_ext_2
dmem_wdata  out  32  to cpu wdata_ext_2
dmem_rdata  in  32  from cpu rdata_ext_2
cpu_enable  out  1  to cpu enable
busy  out  1  high while a segment is being written or verified
done  out  1  one-cycle pulse per completed segment
error  out  1  sticky readback mismatch flag

Behaviour:
- Reset: one clock and a synchronous active-high reset, clk and rst.
  - All outputs are registered.
  - On a clk edge with rst=1, every output goes to 0 and the state goes to HDR.
  - s_ready rises the first cycle after rst deasserts.
  - Reset mid-segment aborts it: no write strobe is issued after the rst edge.
- States: HDR, WRITE, VERIFY (only with the optional feature), RUN.
- HDR: s_ready=1.
  - Header fields: region=s_data[31] (0=imem, 1=dmem), base=s_data[30:16], count=s_data[15:0].
  - On handshake with count==0: go to RUN.
  - On handshake with count!=0: latch region, base and count, clear idx, go to WRITE.
- WRITE: s_ready=1, busy=1.
  - Each handshake issues, on the following cycle, exactly one wen pulse on the selected memory with addr=((base+idx) mod 2^AW)*ADDR_STEP and wdata=s_data. idx then increments.
  - Cycles with s_valid=0 produce no strobe and leave idx unchanged.
  - On the handshake with idx==count-1: go to HDR (or VERIFY). done pulses in the same cycle as the final wen.
- Memory strobes:
  - imem_wen and dmem_wen are never high together.
  - The unselected memory's addr/wdata hold their previous values.
  - imem_ren/dmem_ren stay 0 outside VERIFY.
- RUN: cpu_enable=1 from the cycle after the count==0 handshake. s_ready=0, stream ignored.
  - halt=1 gives cpu_enable=0 on the next cycle and returns to HDR.
  - halt is ignored in every other state.
  - halt and rst together: rst wins.
- Back-to-back segments are allowed: a header may be accepted in the cycle right after the final payload handshake.
- busy=0 in HDR and RUN.

Optional Feature:
- Macro: CPU_PROGRAM_LOADER_READBACK_EN.
- Defined: during WRITE, XOR all written words into wr_sum. After the last word, enter VERIFY.
  - VERIFY issues ren on the selected memory for each index base..base+count-1, one per cycle, at the same addresses as WRITE. s_ready=0.
  - rdata is valid one cycle after ren and is XORed into rd_sum.
  - After the last rdata: if rd_sum!=wr_sum, set error=1 (sticky until rst). Then go to HDR.
  - done pulses on leaving VERIFY instead of on the final wen.
- Undefined: no VERIFY state, error tied 0, ren outputs tied 0, rdata inputs unused.

Test Plan:
- Header 0x0000_0003, words 0x11,0x22,0x33 back-to-back -> imem_wen pulses at addr 0,4,8 with data 0x11,0x22,0x33; dmem_wen never high; one done pulse.
- Header 0x8005_0002, words 0xAAAA_0000,0x5555_FFFF -> dmem_wen at addr 20,24 with those words; imem untouched.
- Same as the first case with s_valid low for 2 cycles between each word -> exactly 3 wen pulses, no duplicates, addresses unchanged.
- Header 0x0000_0000 -> cpu_enable=1 the next cycle, s_ready=0. halt pulse -> cpu_enable=0 and s_ready=1 the next cycle.
- Header 0x01FF_0002 (imem, base 511) -> writes at addr 2044 then 0, the wrap; rst asserted after the first of three payload words in another segment -> no further wen, all outputs 0, next header accepted normally.
- With the macro defined: the memory model corrupts the second readback word -> error=1 after VERIFY and stays 1 across later segments until rst.
